student_event_gen: RTL and testbench
====================================

// Module: student_event_gen
// PURPOSE
//  Upstream stimulus stage for the student schedule FSM: a time-of-day engine that
//  produces the event inputs (alarm, bus, class, hungry, tired, energy) the FSM consumes.
//  Tracks minute-of-day, day-of-week, and hunger/fatigue accumulators.
//  Takes the FSM's state_out back as state_in to model eating, sleeping and gym effects.
// PARAMETERS
//  TICKS_PER_MIN  1     clk cycles per simulated minute (prescaler, >=1)
//  WAKE_MIN       450   minute of day the alarm first rings (07:30)
//  SNOOZE_MINS    9     minutes between snooze and re-ring
//  MAX_SNOOZE     3     snoozes allowed per day
//  BUS_MIN        480   bus window start minute
//  BUS_WIN        10    bus window length, minutes
//  CLASS_START    540   class window start minute (inclusive)
//  CLASS_END      1020  class window end minute (exclusive)
//  HUNGRY_TH      200   hunger >= value -> hungry
//  TIRED_TH       220   fatigue >= value -> tired
//  ENERGY_TH      64    fatigue < value -> energy
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous reset, active low
//  en             in   1   advance time; 0 freezes all counters
//  snooze         in   1   sampled only while alarm=1
//  state_in       in   5   FSM state (SLEEP=0, EAT=1, GYM=8)
//  alarm          out  1   one-cycle pulse at wake / re-ring
//  bus            out  1   level, bus window
//  class          out  1   level, class window on weekdays
//  hungry         out  1   level, hunger >= HUNGRY_TH
//  tired          out  1   level, fatigue >= TIRED_TH
//  energy         out  1   level, fatigue < ENERGY_TH
//  minute_of_day  out  11  0..1439
//  day_count      out  8   days elapsed, wraps 255->0
// BEHAVIOUR
//  Reset (async, rst=0): prescaler, minute, day, hunger, fatigue, snooze_cnt = 0.
//   Alarm FSM -> IDLE. alarm/bus/class/hungry/tired = 0; energy = 1.
//   Asserting reset mid-day clears state immediately.
//  Prescaler: counts 0..TICKS_PER_MIN-1 only while en=1.
//   tick = en & prescaler==TICKS_PER_MIN-1.
//  On tick:
//   - minute increments; 1439 wraps to 0 and increments day_count (mod 256).
//   - Hunger (8b): -8 if state_in==EAT (floor 0), else +1 (sat 255).
//   - Fatigue (8b): -4 if SLEEP (floor 0); +2 if GYM; else +1; sat 255.
//   - All updates use state_in as sampled on the tick cycle.
//  Level outputs are combinational decodes of the current registers (0-cycle latency):
//   - bus   = minute in [BUS_MIN, BUS_MIN+BUS_WIN).
//   - class = minute in [CLASS_START, CLASS_END) && (day_count % 7) < 5.
//  Alarm FSM: IDLE, RING, SNOOZED.
//   - IDLE -> RING on the tick where next minute == WAKE_MIN.
//   - RING lasts exactly one cycle with alarm=1.
//     snooze=1 && snooze_cnt<MAX_SNOOZE: snooze_cnt++, load snz_timer=SNOOZE_MINS, -> SNOOZED.
//     Otherwise -> IDLE.
//   - SNOOZED: snz_timer decrements per tick; reaching 0 on a tick -> RING.
//   - Day wrap clears snooze_cnt and forces IDLE.
//     If a wrap and a re-ring fall on the same tick, the wrap wins.
//  en=0 holds every register; alarm never asserts while en=0.
//  Edge cases: WAKE_MIN out of range -> alarm never rings. Counters saturate; they do not wrap.
// TESTING
//  T1 Reset: rst=0 mid-day -> next cycle minute=0, day=0, energy=1, all other outputs 0.
//  T2 Alarm: TICKS_PER_MIN=1, run 450 ticks, snooze=0 -> alarm high exactly 1 cycle at minute 450, none again that day.
//  T3 Snooze: snooze=1 on every ring -> rings at 450, 459, 468, 477; no fifth ring; next day rings at 450 again.
//  T4 Windows: day 0 -> bus=1 for minutes 480..489, class=1 for 540..1019; day 5 (Sat) -> class=0 all day.
//  T5 Accumulators: 200 ticks non-SLEEP, non-EAT -> hungry=1, energy=0.
//     Then 25 ticks of EAT -> hunger=0, hungry=0.
//     255+ GYM ticks -> fatigue holds at 255.
//  T6 Freeze/wrap: en=0 for 100 cycles -> minute unchanged.
//     Minute 1439 + tick -> minute=0, day_count+1; day_count 255 wraps to 0.

Source files
------------

// File: rtl/student_event_gen.sv
// Time-of-day stimulus engine for the student schedule FSM: minute/day counters,
// hunger/fatigue accumulators and a snoozable wake-up alarm.
module student_event_gen #(
    parameter int TICKS_PER_MIN = 1,
    parameter int WAKE_MIN      = 450,
    parameter int SNOOZE_MINS   = 9,
    parameter int MAX_SNOOZE    = 3,
    parameter int BUS_MIN       = 480,
    parameter int BUS_WIN       = 10,
    parameter int CLASS_START   = 540,
    parameter int CLASS_END     = 1020,
    parameter int HUNGRY_TH     = 200,
    parameter int TIRED_TH      = 220,
    parameter int ENERGY_TH     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        snooze,
    input  logic [4:0]  state_in,
    output logic        alarm,
    output logic        bus,
    output logic        class_on,
    output logic        hungry,
    output logic        tired,
    output logic        energy,
    output logic [10:0] minute_of_day,
    output logic [7:0]  day_count
);

    localparam int              PW       = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICKS_PER_MIN - 1);
    localparam logic [4:0]      ST_SLEEP = 5'd0;
    localparam logic [4:0]      ST_EAT   = 5'd1;
    localparam logic [4:0]      ST_GYM   = 5'd8;
    localparam int              BUS_END  = BUS_MIN + BUS_WIN;

    typedef enum logic [1:0] {
        A_IDLE,
        A_RING,
        A_SNOOZED
    } alarm_state_t;

    logic [PW-1:0]  pre_q, pre_d;
    logic [10:0]    minute_q, minute_d;
    logic [7:0]     day_q, day_d;
    logic [7:0]     hunger_q, hunger_d;
    logic [7:0]     fatigue_q, fatigue_d;
    logic [7:0]     snooze_cnt_q, snooze_cnt_d;
    logic [10:0]    timer_q, timer_d;
    alarm_state_t   state_q, state_d;

    logic tick;
    logic wrap;

    assign tick = en && (pre_q == PRE_LAST);
    assign wrap = (minute_q == 11'd1439);

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        pre_d        = pre_q;
        minute_d     = minute_q;
        day_d        = day_q;
        hunger_d     = hunger_q;
        fatigue_d    = fatigue_q;
        snooze_cnt_d = snooze_cnt_q;
        timer_d      = timer_q;
        state_d      = state_q;

        if (en)
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);

        if (tick) begin
            minute_d = wrap ? 11'd0 : minute_q + 11'd1;
            if (wrap)
                day_d = day_q + 8'd1;

            if (state_in == ST_EAT)
                hunger_d = (hunger_q < 8'd8) ? 8'd0 : hunger_q - 8'd8;
            else if (hunger_q != 8'd255)
                hunger_d = hunger_q + 8'd1;

            if (state_in == ST_SLEEP)
                fatigue_d = (fatigue_q < 8'd4) ? 8'd0 : fatigue_q - 8'd4;
            else if (state_in == ST_GYM)
                fatigue_d = (fatigue_q > 8'd253) ? 8'd255 : fatigue_q + 8'd2;
            else if (fatigue_q != 8'd255)
                fatigue_d = fatigue_q + 8'd1;
        end

        case (state_q)
            A_IDLE: begin
                if (tick && int'(minute_d) == WAKE_MIN)
                    state_d = A_RING;
            end
            A_RING: begin
                if (en) begin
                    if (snooze && int'(snooze_cnt_q) < MAX_SNOOZE) begin
                        snooze_cnt_d = snooze_cnt_q + 8'd1;
                        // The ring cycle itself ends a minute when it coincides with a tick.
                        timer_d      = tick ? 11'(SNOOZE_MINS - 1) : 11'(SNOOZE_MINS);
                        state_d      = A_SNOOZED;
                    end else begin
                        state_d = A_IDLE;
                    end
                end
            end
            A_SNOOZED: begin
                if (tick) begin
                    if (timer_q <= 11'd1) begin
                        timer_d = 11'd0;
                        state_d = A_RING;
                    end else begin
                        timer_d = timer_q - 11'd1;
                    end
                end
            end
            default: state_d = A_IDLE;
        endcase

        // Midnight starts a fresh day and overrides any pending re-ring.
        if (tick && wrap) begin
            state_d      = A_IDLE;
            snooze_cnt_d = 8'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q        <= '0;
            minute_q     <= 11'd0;
            day_q        <= 8'd0;
            hunger_q     <= 8'd0;
            fatigue_q    <= 8'd0;
            snooze_cnt_q <= 8'd0;
            timer_q      <= 11'd0;
            state_q      <= A_IDLE;
        end else begin
            pre_q        <= pre_d;
            minute_q     <= minute_d;
            day_q        <= day_d;
            hunger_q     <= hunger_d;
            fatigue_q    <= fatigue_d;
            snooze_cnt_q <= snooze_cnt_d;
            timer_q      <= timer_d;
            state_q      <= state_d;
        end
    end

    assign alarm         = (state_q == A_RING) && en;
    assign bus           = (int'(minute_q) >= BUS_MIN) && (int'(minute_q) < BUS_END);
    assign class_on      = (int'(minute_q) >= CLASS_START) && (int'(minute_q) < CLASS_END)
                           && ((day_q % 8'd7) < 8'd5);
    assign hungry        = int'(hunger_q) >= HUNGRY_TH;
    assign tired         = int'(fatigue_q) >= TIRED_TH;
    assign energy        = int'(fatigue_q) < ENERGY_TH;
    assign minute_of_day = minute_q;
    assign day_count     = day_q;

endmodule

// File: tb/tb_student_event_gen.sv
// Directed bench for student_event_gen: stimulus pushes expected snapshots and alarm
// events into queues; a negedge monitor pops and compares them.
module tb_student_event_gen;

    localparam logic [4:0] SLEEP   = 5'd0;
    localparam logic [4:0] EAT     = 5'd1;
    localparam logic [4:0] NEUTRAL = 5'd2;
    localparam logic [4:0] GYM     = 5'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        snooze = 1'b0;
    logic [4:0]  state_in = NEUTRAL;
    logic        alarm, bus, class_on, hungry, tired, energy;
    logic [10:0] minute_of_day;
    logic [7:0]  day_count;

    student_event_gen dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .snooze        (snooze),
        .state_in      (state_in),
        .alarm         (alarm),
        .bus           (bus),
        .class_on      (class_on),
        .hungry        (hungry),
        .tired         (tired),
        .energy        (energy),
        .minute_of_day (minute_of_day),
        .day_count     (day_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Level vector order: alarm, bus, class, hungry, tired, energy.
    wire [5:0] lv = {alarm, bus, class_on, hungry, tired, energy};

    typedef struct {
        int unsigned cyc;
        int          min;
        int          day;
        logic [5:0]  lv;
        string       name;
    } snap_t;

    typedef struct {
        int min;
        int day;
    } ring_t;

    snap_t snap_q[$];
    ring_t ring_q[$];
    snap_t s;
    ring_t r;
    int    vectors = 0;
    int    miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap(input string name, input int m, input int d, input logic [5:0] l);
        snap_q.push_back('{cyc, m, d, l, name});
    endtask

    task automatic ring(input int d, input int m);
        ring_q.push_back('{m, d});
    endtask

    always @(negedge clk) begin
        if (alarm) begin
            if (ring_q.size() == 0) begin
                check("alarm_spurious", int'(alarm), 0);
            end else begin
                r = ring_q.pop_front();
                check("alarm_min", int'(minute_of_day), r.min);
                check("alarm_day", int'(day_count), r.day);
            end
        end
        if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
            s = snap_q.pop_front();
            check({s.name, "_min"}, int'(minute_of_day), s.min);
            check({s.name, "_day"}, int'(day_count), s.day);
            check({s.name, "_levels"}, int'(lv), int'(s.lv));
        end
    end

    initial begin
        run(2);
        snap("reset", 0, 0, 6'b000001);
        rst = 1'b1;
        en  = 1'b1;
        ring(0, 450);

        // Accumulators
        run(63);  snap("acc_m63", 63, 0, 6'b000001);
        run(1);   snap("energy_drop", 64, 0, 6'b000000);
        run(136); snap("hungry_on", 200, 0, 6'b000100);
        state_in = EAT;
        run(1);   snap("eat_first", 201, 0, 6'b000000);
        run(18);  snap("eat_m219", 219, 0, 6'b000000);
        run(1);   snap("tired_on", 220, 0, 6'b000010);
        run(5);   snap("hunger_zero", 225, 0, 6'b000010);
        run(3);   snap("hunger_floor", 228, 0, 6'b000010);
        state_in = NEUTRAL;
        run(199); snap("refill_199", 427, 0, 6'b000010);
        run(1);   snap("refill_200", 428, 0, 6'b000110);
        state_in = SLEEP;
        run(8);   snap("sleep_223", 436, 0, 6'b000110);
        run(1);   snap("sleep_219", 437, 0, 6'b000100);
        run(38);  snap("sleep_67", 475, 0, 6'b000100);
        run(1);   snap("energy_back", 476, 0, 6'b000101);
        run(20);  snap("fatigue_floor", 496, 0, 6'b000101);
        state_in = GYM;
        run(31);  snap("gym_62", 527, 0, 6'b000101);
        run(1);   snap("gym_64", 528, 0, 6'b000100);
        run(224); snap("gym_sat", 752, 0, 6'b001110);
        state_in = SLEEP;
        run(8);   snap("sat_223", 760, 0, 6'b001110);
        run(1);   snap("sat_219", 761, 0, 6'b001100);

        // Mid-day reset
        run(1);
        rst = 1'b0;
        snap("midday_reset", 0, 0, 6'b000001);
        run(1);   snap("reset_hold", 0, 0, 6'b000001);
        rst = 1'b1;

        // Day 0: single alarm, bus and class windows
        ring(0, 450);
        run(449); snap("pre_alarm", 449, 0, 6'b000101);
        run(1);   snap("alarm_450", 450, 0, 6'b100101);
        run(1);   snap("alarm_gone", 451, 0, 6'b000101);
        run(28);  snap("bus_before", 479, 0, 6'b000101);
        run(1);   snap("bus_first", 480, 0, 6'b010101);
        run(9);   snap("bus_last", 489, 0, 6'b010101);
        run(1);   snap("bus_after", 490, 0, 6'b000101);
        run(49);  snap("class_before", 539, 0, 6'b000101);
        run(1);   snap("class_first", 540, 0, 6'b001101);
        run(479); snap("class_last", 1019, 0, 6'b001101);
        run(1);   snap("class_after", 1020, 0, 6'b000101);
        run(419); snap("day0_end", 1439, 0, 6'b000101);
        run(1);   snap("day1_start", 0, 1, 6'b000101);

        // Day 1: snooze every ring
        snooze = 1'b1;
        ring(1, 450); ring(1, 459); ring(1, 468); ring(1, 477);
        run(450); snap("snz_ring1", 450, 1, 6'b100101);
        run(9);   snap("snz_ring2", 459, 1, 6'b100101);
        run(18);  snap("snz_ring4", 477, 1, 6'b100101);
        run(1);   snap("snz_after4", 478, 1, 6'b000101);
        run(962); snap("day2_start", 0, 2, 6'b000101);
        snooze = 1'b0;
        ring(2, 450);
        run(451); snap("day2_post_ring", 451, 2, 6'b000101);

        // Days 3..5, freeze, Saturday
        ring(3, 450); ring(4, 450);
        run(4318); snap("sat_pre", 449, 5, 6'b000101);
        en = 1'b0;
        run(100); snap("freeze", 449, 5, 6'b000101);
        en = 1'b1;
        ring(5, 450);
        run(1);   snap("sat_ring", 450, 5, 6'b100101);
        run(30);  snap("sat_bus", 480, 5, 6'b010101);
        run(60);  snap("sat_no_class", 540, 5, 6'b000101);
        run(479); snap("sat_no_class_end", 1019, 5, 6'b000101);

        // Day counter 255 -> 0
        run(419);
        force dut.day_q = 8'd255;
        run(1);
        release dut.day_q;
        snap("day255", 1439, 255, 6'b000101);
        ring(0, 450);
        run(1);   snap("day_wrap", 0, 0, 6'b000101);
        run(540); snap("wrap_class", 540, 0, 6'b001101);

        run(2);
        check("rings_pending", ring_q.size(), 0);
        check("snaps_pending", snap_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
